// File: rtl/conv_sequencer.sv
`timescale 1ns/1ps
// Control sequencer for the convolution accelerator: loads NKERNEL filters once, then for each
// output position fetches the input window, runs one MAC pass per kernel and writes each result.
module conv_sequencer #(
  parameter int NKERNEL = 4,
  parameter int KSIZE   = 3,
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 16,
  parameter int STRIDE  = 1,
  parameter int ADDR_W  = 8,
  localparam int KK     = KSIZE * KSIZE,
  localparam int TAP_W  = (KK > 1) ? $clog2(KK) : 1,
  localparam int KERN_W = (NKERNEL > 1) ? $clog2(NKERNEL) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_img_base,
  input  logic [ADDR_W-1:0]  i_flt_base,
  input  logic [ADDR_W-1:0]  i_out_base,
  input  logic               i_mem_ready,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_mem_rd,
  output logic               o_mem_wr,
  output logic [NKERNEL-1:0] o_flt_load,
  output logic [TAP_W-1:0]   o_flt_tap,
  output logic [TAP_W-1:0]   o_win_tap,
  output logic [TAP_W-1:0]   o_mac_tap,
  output logic               o_win_load,
  output logic               o_mac_clr,
  output logic               o_mac_en,
  output logic [KERN_W-1:0]  o_mac_kern,
  output logic               o_busy,
  output logic               o_done
);
  localparam int OUT_W = (IMG_W - KSIZE) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - KSIZE) / STRIDE + 1;
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_FLT, S_LOAD_WIN, S_CLR, S_MAC, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t            r_state;
  logic [KERN_W-1:0] r_n;
  logic [TAP_W-1:0]  r_t;
  logic [ROW_W-1:0]  r_r;
  logic [COL_W-1:0]  r_c;
  logic [ADDR_W-1:0] r_img_base;
  logic [ADDR_W-1:0] r_flt_base;
  logic [ADDR_W-1:0] r_out_base;

  logic              w_last_tap;
  logic              w_last_kern;
  logic              w_last_col;
  logic              w_last_row;
  logic [ADDR_W-1:0] w_flt_addr;
  logic [ADDR_W-1:0] w_win_addr;
  logic [ADDR_W-1:0] w_out_addr;

  assign w_last_tap  = (r_t == TAP_W'(KK - 1));
  assign w_last_kern = (r_n == KERN_W'(NKERNEL - 1));
  assign w_last_col  = (r_c == COL_W'(OUT_W - 1));
  assign w_last_row  = (r_r == ROW_W'(OUT_H - 1));

  // Computed at 32 bits and truncated, so addresses wrap modulo 2^ADDR_W.
  assign w_flt_addr = ADDR_W'(32'(r_flt_base) + 32'(r_n) * 32'(KK) + 32'(r_t));
  assign w_win_addr = ADDR_W'(32'(r_img_base)
                      + (32'(r_r) * 32'(STRIDE) + 32'(r_t) / 32'(KSIZE)) * 32'(IMG_W)
                      + 32'(r_c) * 32'(STRIDE) + 32'(r_t) % 32'(KSIZE));
  assign w_out_addr = ADDR_W'(32'(r_out_base) + 32'(r_n) * 32'(OUT_H * OUT_W)
                      + 32'(r_r) * 32'(OUT_W) + 32'(r_c));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_t        <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_img_base <= '0;
      r_flt_base <= '0;
      r_out_base <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_img_base <= i_img_base;
            r_flt_base <= i_flt_base;
            r_out_base <= i_out_base;
            r_n        <= '0;
            r_t        <= '0;
            r_r        <= '0;
            r_c        <= '0;
            r_state    <= S_LOAD_FLT;
          end
        end
        S_LOAD_FLT: begin
          if (i_mem_ready) begin
            if (w_last_tap) begin
              r_t <= '0;
              if (w_last_kern) begin
                r_n     <= '0;
                r_state <= S_LOAD_WIN;
              end else begin
                r_n <= r_n + 1'b1;
              end
            end else begin
              r_t <= r_t + 1'b1;
            end
          end
        end
        S_LOAD_WIN: begin
          if (i_mem_ready) begin
            if (w_last_tap) begin
              r_t     <= '0;
              r_state <= S_CLR;
            end else begin
              r_t <= r_t + 1'b1;
            end
          end
        end
        S_CLR: begin
          r_t     <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          if (w_last_tap) begin
            r_t     <= '0;
            r_state <= S_WRITE;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        S_WRITE: begin
          if (i_mem_ready) begin
            if (w_last_kern) begin
              r_state <= S_NEXT;
            end else begin
              r_n     <= r_n + 1'b1;
              r_state <= S_CLR;
            end
          end
        end
        S_NEXT: begin
          r_n <= '0;
          if (w_last_col) begin
            r_c <= '0;
            r_r <= w_last_row ? '0 : r_r + 1'b1;
          end else begin
            r_c <= r_c + 1'b1;
          end
          r_state <= (w_last_col && w_last_row) ? S_DONE : S_LOAD_WIN;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; load strobes also need the completing mem_ready.
  always_comb begin
    o_mem_addr = '0;
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_flt_load = '0;
    o_flt_tap  = '0;
    o_win_tap  = '0;
    o_mac_tap  = '0;
    o_win_load = 1'b0;
    o_mac_clr  = 1'b0;
    o_mac_en   = 1'b0;
    o_mac_kern = '0;
    o_busy     = (r_state != S_IDLE);
    o_done     = 1'b0;
    case (r_state)
      S_LOAD_FLT: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = w_flt_addr;
        o_flt_tap  = r_t;
        if (i_mem_ready) o_flt_load = NKERNEL'(1) << r_n;
      end
      S_LOAD_WIN: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = w_win_addr;
        o_win_tap  = r_t;
        o_win_load = i_mem_ready;
      end
      S_CLR: o_mac_clr = 1'b1;
      S_MAC: begin
        o_mac_en   = 1'b1;
        o_mac_tap  = r_t;
        o_mac_kern = r_n;
      end
      S_WRITE: begin
        o_mem_wr   = 1'b1;
        o_mem_addr = w_out_addr;
        o_mac_kern = r_n;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end
endmodule
